// File: rtl/tiny_alu_pkg.sv
// Shared types and defaults for the tiny ALU issue controller and its command buffer.
package tiny_alu_pkg;

  localparam int DEF_INPUT_DATA_BITS = 8;
  localparam int DEF_OPCODE_BITS     = 3;

  typedef enum logic [DEF_OPCODE_BITS-1:0] {
    OP_NOP = 3'd0,
    OP_ADD = 3'd1,
    OP_AND = 3'd2,
    OP_XOR = 3'd3,
    OP_MUL = 3'd4
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BUSY,
    ST_RESP
  } issue_state_e;

  // Opcodes that actually need the ALU; everything else is answered locally.
  function automatic logic is_alu_op(input logic [31:0] op);
    return (op >= 32'(OP_ADD)) && (op <= 32'(OP_MUL));
  endfunction

  function automatic logic is_nop(input logic [31:0] op);
    return op == 32'(OP_NOP);
  endfunction

endpackage

// File: rtl/tiny_alu_issue_fifo.sv
// Synchronous command buffer: combinational head read, registered full/empty flags.
module tiny_alu_issue_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rd_data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int PTR_BITS = $clog2(DEPTH);
  localparam int CNT_BITS = PTR_BITS + 1;

  logic [WIDTH-1:0]    mem_q [DEPTH];
  logic [PTR_BITS-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_BITS-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_BITS-1:0] count_q, count_d;
  logic                full_q, full_d;
  logic                empty_q, empty_d;
  logic                do_push, do_pop;

  // NOTE: every always_comb output gets a value before any branch, so no latch can be inferred.
  always_comb begin
    do_push  = push_i && !full_q;
    do_pop   = pop_i && !empty_q;
    wr_ptr_d = wr_ptr_q + PTR_BITS'(do_push);
    rd_ptr_d = rd_ptr_q + PTR_BITS'(do_pop);
    count_d  = count_q + CNT_BITS'(do_push) - CNT_BITS'(do_pop);
    full_d   = (count_d == CNT_BITS'(DEPTH));
    empty_d  = (count_d == '0);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
    end
  end

  // NOTE: storage is not reset; the pointers and flags alone decide which entries are valid.
  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= wr_data_i;
    end
  end

  assign rd_data_o = mem_q[rd_ptr_q];
  assign full_o    = full_q;
  assign empty_o   = empty_q;

endmodule

// File: rtl/tiny_alu_issue_ctrl.sv
// Issue controller for a tiny multi-cycle ALU: buffers commands, issues them one at a
// time in acceptance order, and returns one response (result or error) per command.
module tiny_alu_issue_ctrl
  import tiny_alu_pkg::*;
#(
  parameter int INPUT_DATA_BITS = DEF_INPUT_DATA_BITS,
  parameter int OPCODE_BITS     = DEF_OPCODE_BITS,
  parameter int FIFO_DEPTH      = 4,
  parameter int TIMEOUT_CYCLES  = 16
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         cmd_valid_i,
  output logic                         cmd_ready_o,
  input  logic [OPCODE_BITS-1:0]       cmd_op_i,
  input  logic [INPUT_DATA_BITS-1:0]   cmd_a_i,
  input  logic [INPUT_DATA_BITS-1:0]   cmd_b_i,
  output logic                         start_o,
  output logic [OPCODE_BITS-1:0]       op_o,
  output logic [INPUT_DATA_BITS-1:0]   a_o,
  output logic [INPUT_DATA_BITS-1:0]   b_o,
  input  logic                         done_i,
  input  logic [2*INPUT_DATA_BITS-1:0] result_i,
  output logic                         rsp_valid_o,
  input  logic                         rsp_ready_i,
  output logic [2*INPUT_DATA_BITS-1:0] rsp_result_o,
  output logic [OPCODE_BITS-1:0]       rsp_op_o,
  output logic                         rsp_err_o
);

  localparam int RES_BITS = 2 * INPUT_DATA_BITS;
  localparam int CMD_BITS = OPCODE_BITS + 2 * INPUT_DATA_BITS;
  localparam int TMO_BITS = $clog2(TIMEOUT_CYCLES + 1);

  issue_state_e               state_q, state_d;
  logic                       start_q, start_d;
  logic [OPCODE_BITS-1:0]     op_q, op_d;
  logic [INPUT_DATA_BITS-1:0] a_q, a_d, b_q, b_d;
  logic [TMO_BITS-1:0]        cnt_q, cnt_d;
  logic                       rsp_valid_q, rsp_valid_d;
  logic [RES_BITS-1:0]        rsp_result_q, rsp_result_d;
  logic [OPCODE_BITS-1:0]     rsp_op_q, rsp_op_d;
  logic                       rsp_err_q, rsp_err_d;

  logic                       fifo_pop, fifo_full, fifo_empty;
  logic [CMD_BITS-1:0]        fifo_rd_data;
  logic [OPCODE_BITS-1:0]     head_op;
  logic [INPUT_DATA_BITS-1:0] head_a, head_b;

  tiny_alu_issue_fifo #(
    .WIDTH (CMD_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .push_i    (cmd_valid_i),
    .wr_data_i ({cmd_op_i, cmd_a_i, cmd_b_i}),
    .pop_i     (fifo_pop),
    .rd_data_o (fifo_rd_data),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty)
  );

  assign {head_op, head_a, head_b} = fifo_rd_data;

  always_comb begin
    state_d      = state_q;
    start_d      = start_q;
    op_d         = op_q;
    a_d          = a_q;
    b_d          = b_q;
    cnt_d        = cnt_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_result_d = rsp_result_q;
    rsp_op_d     = rsp_op_q;
    rsp_err_d    = rsp_err_q;
    fifo_pop     = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          op_d     = head_op;
          a_d      = head_a;
          b_d      = head_b;
          cnt_d    = '0;
          if (is_alu_op(32'(head_op))) begin
            state_d = ST_BUSY;
          end else begin
            // NOP and undefined opcodes never reach the ALU.
            state_d      = ST_RESP;
            rsp_valid_d  = 1'b1;
            rsp_result_d = '0;
            rsp_op_d     = head_op;
            rsp_err_d    = !is_nop(32'(head_op));
          end
        end
      end

      ST_BUSY: begin
        start_d = 1'b1;
        if (done_i) begin
          start_d      = 1'b0;
          state_d      = ST_RESP;
          rsp_valid_d  = 1'b1;
          rsp_result_d = result_i;
          rsp_op_d     = op_q;
          rsp_err_d    = 1'b0;
        end else if (cnt_q == TMO_BITS'(TIMEOUT_CYCLES - 1)) begin
          start_d      = 1'b0;
          state_d      = ST_RESP;
          rsp_valid_d  = 1'b1;
          rsp_result_d = '0;
          rsp_op_d     = op_q;
          rsp_err_d    = 1'b1;
        end else begin
          cnt_d = cnt_q + TMO_BITS'(1);
        end
      end

      ST_RESP: begin
        if (rsp_ready_i) begin
          rsp_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= ST_IDLE;
      start_q      <= 1'b0;
      op_q         <= '0;
      a_q          <= '0;
      b_q          <= '0;
      cnt_q        <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_result_q <= '0;
      rsp_op_q     <= '0;
      rsp_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      start_q      <= start_d;
      op_q         <= op_d;
      a_q          <= a_d;
      b_q          <= b_d;
      cnt_q        <= cnt_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_result_q <= rsp_result_d;
      rsp_op_q     <= rsp_op_d;
      rsp_err_q    <= rsp_err_d;
    end
  end

  assign cmd_ready_o  = !fifo_full;
  assign start_o      = start_q;
  assign op_o         = op_q;
  assign a_o          = a_q;
  assign b_o          = b_q;
  assign rsp_valid_o  = rsp_valid_q;
  assign rsp_result_o = rsp_result_q;
  assign rsp_op_o     = rsp_op_q;
  assign rsp_err_o    = rsp_err_q;

endmodule

// File: tb/tb_tiny_alu_issue_ctrl.sv
// Self-checking bench for tiny_alu_issue_ctrl: an ALU stub answers start_o, and every
// response is compared with an arithmetic model of the command stream.
module tb_tiny_alu_issue_ctrl;

  localparam int DW      = 8;
  localparam int OW      = 3;
  localparam int RW      = 2 * DW;
  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 16;

  typedef struct packed {
    logic [OW-1:0] op;
    logic          err;
    logic [RW-1:0] result;
  } rsp_t;

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b1;
  logic          cmd_valid_i = 1'b0;
  logic          cmd_ready_o;
  logic [OW-1:0] cmd_op_i = '0;
  logic [DW-1:0] cmd_a_i = '0;
  logic [DW-1:0] cmd_b_i = '0;
  logic          start_o;
  logic [OW-1:0] op_o;
  logic [DW-1:0] a_o;
  logic [DW-1:0] b_o;
  logic          done_i = 1'b0;
  logic [RW-1:0] result_i = '0;
  logic          rsp_valid_o;
  logic          rsp_ready_i = 1'b1;
  logic [RW-1:0] rsp_result_o;
  logic [OW-1:0] rsp_op_o;
  logic          rsp_err_o;

  int   n_checks = 0;
  int   n_fail   = 0;
  rsp_t exp_q[$];
  rsp_t obs_q[$];
  int   done_delay = 1;   // ALU answers this many cycles after start_o is seen; <0 never
  int   start_seen = 0;
  int   n_starts   = 0;

  tiny_alu_issue_ctrl #(
    .INPUT_DATA_BITS (DW),
    .OPCODE_BITS     (OW),
    .FIFO_DEPTH      (DEPTH),
    .TIMEOUT_CYCLES  (TIMEOUT)
  ) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .cmd_valid_i  (cmd_valid_i),
    .cmd_ready_o  (cmd_ready_o),
    .cmd_op_i     (cmd_op_i),
    .cmd_a_i      (cmd_a_i),
    .cmd_b_i      (cmd_b_i),
    .start_o      (start_o),
    .op_o         (op_o),
    .a_o          (a_o),
    .b_o          (b_o),
    .done_i       (done_i),
    .result_i     (result_i),
    .rsp_valid_o  (rsp_valid_o),
    .rsp_ready_i  (rsp_ready_i),
    .rsp_result_o (rsp_result_o),
    .rsp_op_o     (rsp_op_o),
    .rsp_err_o    (rsp_err_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [RW-1:0] alu_calc(input logic [OW-1:0] op, input logic [DW-1:0] a,
                                             input logic [DW-1:0] b);
    case (op)
      3'd1:    return RW'(a) + RW'(b);
      3'd2:    return RW'(a & b);
      3'd3:    return RW'(a ^ b);
      3'd4:    return RW'(a) * RW'(b);
      default: return '0;
    endcase
  endfunction

  // Expected response: legal ops give the arithmetic result (or timeout error),
  // NOP gives 0/ok, anything above MUL gives 0/error.
  function automatic rsp_t model(input logic [OW-1:0] op, input logic [DW-1:0] a,
                                 input logic [DW-1:0] b, input bit timeout);
    rsp_t r;
    r.op     = op;
    r.err    = (op > 3'd4);
    r.result = '0;
    if (op >= 3'd1 && op <= 3'd4) begin
      if (timeout) r.err = 1'b1;
      else         r.result = alu_calc(op, a, b);
    end
    return r;
  endfunction

  // ALU stub
  initial begin
    forever begin
      @(posedge clk_i); #1;
      done_i = 1'b0;
      if (start_o === 1'b1) begin
        if (start_seen == 0) n_starts++;
        start_seen++;
        if (done_delay >= 0 && start_seen >= done_delay + 1) begin
          done_i   = 1'b1;
          result_i = alu_calc(op_o, a_o, b_o);
        end
      end else begin
        start_seen = 0;
      end
    end
  end

  // Record every response handshake that will complete at the next rising edge.
  always @(negedge clk_i) begin
    if (rst_i === 1'b0 && rsp_valid_o === 1'b1 && rsp_ready_i === 1'b1)
      obs_q.push_back({rsp_op_o, rsp_err_o, rsp_result_o});
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic push_cmd(input logic [OW-1:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b);
    int guard = 0;
    while (cmd_ready_o !== 1'b1 && guard < 500) begin
      @(posedge clk_i); #1;
      guard++;
    end
    if (cmd_ready_o !== 1'b1) begin
      n_checks++; n_fail++;
      $display("FAIL push_wait: cmd_ready_o=%b after %0d cycles, required 1", cmd_ready_o, guard);
    end
    cmd_valid_i = 1'b1;
    cmd_op_i    = op;
    cmd_a_i     = a;
    cmd_b_i     = b;
    @(posedge clk_i); #1;
    cmd_valid_i = 1'b0;
    exp_q.push_back(model(op, a, b, done_delay < 0));
  endtask

  task automatic wait_rsps(input int n, input string name);
    int guard = 0;
    while (obs_q.size() < n && guard < 3000) begin
      @(posedge clk_i); #1;
      guard++;
    end
    if (obs_q.size() < n) begin
      n_checks++; n_fail++;
      $display("FAIL %s_wait: got %0d responses, required %0d", name, obs_q.size(), n);
    end
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    repeat (2) @(posedge clk_i);
    #1 rst_i = 1'b0;
    n_checks++;
    if ({start_o, op_o, a_o, b_o, rsp_valid_o, rsp_result_o, rsp_op_o, rsp_err_o} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: start=%b op=%0d a=%h b=%h rsp_valid=%b res=%h rsp_op=%0d err=%b, required all 0",
               start_o, op_o, a_o, b_o, rsp_valid_o, rsp_result_o, rsp_op_o, rsp_err_o);
    end
    n_checks++;
    if (cmd_ready_o !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_ready: cmd_ready_o=%b, required 1", cmd_ready_o);
    end
  endtask

  task automatic test_add();
    int   lat = 0;
    int   len = 0;
    rsp_t o, e;
    done_delay = 1;
    push_cmd(3'd1, 8'h05, 8'h07);
    while (start_o !== 1'b1 && lat < 20) begin
      @(posedge clk_i); #1;
      lat++;
    end
    n_checks++;
    if (lat != 2) begin
      n_fail++;
      $display("FAIL add_start_latency: %0d cycles, required 2", lat);
    end
    n_checks++;
    if ({op_o, a_o, b_o} !== {3'd1, 8'h05, 8'h07}) begin
      n_fail++;
      $display("FAIL add_operands: op=%0d a=%h b=%h, required 1/05/07", op_o, a_o, b_o);
    end
    while (start_o === 1'b1 && len < 40) begin
      len++;
      @(posedge clk_i); #1;
    end
    n_checks++;
    if (len != 2) begin
      n_fail++;
      $display("FAIL add_start_len: %0d cycles, required 2", len);
    end
    wait_rsps(1, "add");
    while (obs_q.size() > 0) begin
      o = obs_q.pop_front();
      if (exp_q.size() == 0) e = '1; else e = exp_q.pop_front();
      n_checks++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL add_rsp: got op=%0d err=%b res=%h, required op=%0d err=%b res=%h",
                 o.op, o.err, o.result, e.op, e.err, e.result);
      end
    end
  endtask

  task automatic test_mul_backpressure();
    int   guard = 0;
    rsp_t o, e;
    done_delay = 3;
    push_cmd(3'd4, 8'hFF, 8'hFF);
    while (start_o !== 1'b1 && guard < 20) begin
      @(posedge clk_i); #1;
      guard++;
    end
    for (int i = 0; i < 4; i++) push_cmd(3'd4, 8'($urandom), 8'($urandom));
    n_checks++;
    if (cmd_ready_o !== 1'b0) begin
      n_fail++;
      $display("FAIL mul_full_ready: cmd_ready_o=%b after four pushes, required 0", cmd_ready_o);
    end
    wait_rsps(5, "mul");
    while (obs_q.size() > 0) begin
      o = obs_q.pop_front();
      if (exp_q.size() == 0) e = '1; else e = exp_q.pop_front();
      n_checks++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL mul_rsp: got op=%0d err=%b res=%h, required op=%0d err=%b res=%h",
                 o.op, o.err, o.result, e.op, e.err, e.result);
      end
    end
  endtask

  task automatic test_illegal_nop();
    int   starts0 = n_starts;
    rsp_t o, e;
    done_delay = 1;
    push_cmd(3'd6, 8'($urandom), 8'($urandom));
    push_cmd(3'd0, 8'($urandom), 8'($urandom));
    wait_rsps(2, "illegal_nop");
    while (obs_q.size() > 0) begin
      o = obs_q.pop_front();
      if (exp_q.size() == 0) e = '1; else e = exp_q.pop_front();
      n_checks++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL illegal_nop_rsp: got op=%0d err=%b res=%h, required op=%0d err=%b res=%h",
                 o.op, o.err, o.result, e.op, e.err, e.result);
      end
    end
    n_checks++;
    if (n_starts != starts0) begin
      n_fail++;
      $display("FAIL illegal_nop_start: %0d start pulses, required 0", n_starts - starts0);
    end
  endtask

  task automatic test_timeout();
    int   lat = 0;
    rsp_t o, e;
    done_delay = -1;
    push_cmd(3'd1, 8'h03, 8'h04);
    while (rsp_valid_o !== 1'b1 && lat < 60) begin
      @(posedge clk_i); #1;
      lat++;
    end
    n_checks++;
    if (lat != TIMEOUT + 1) begin
      n_fail++;
      $display("FAIL timeout_latency: response %0d cycles after push, required %0d", lat, TIMEOUT + 1);
    end
    n_checks++;
    if (start_o !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout_start: start_o=%b in response, required 0", start_o);
    end
    wait_rsps(1, "timeout");
    while (obs_q.size() > 0) begin
      o = obs_q.pop_front();
      if (exp_q.size() == 0) e = '1; else e = exp_q.pop_front();
      n_checks++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL timeout_rsp: got op=%0d err=%b res=%h, required op=%0d err=%b res=%h",
                 o.op, o.err, o.result, e.op, e.err, e.result);
      end
    end
    done_delay = 1;
  endtask

  task automatic test_rsp_stall();
    int   guard = 0;
    rsp_t first, o, e;
    rsp_ready_i = 1'b0;
    done_delay  = 1;
    push_cmd(3'd2, 8'($urandom), 8'($urandom));
    push_cmd(3'd3, 8'($urandom), 8'($urandom));
    first = exp_q[0];
    while (rsp_valid_o !== 1'b1 && guard < 40) begin
      @(posedge clk_i); #1;
      guard++;
    end
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if ({rsp_valid_o, rsp_op_o, rsp_err_o, rsp_result_o} !== {1'b1, first}) begin
        n_fail++;
        $display("FAIL stall_hold[%0d]: valid=%b op=%0d err=%b res=%h, required 1/%0d/%b/%h", i,
                 rsp_valid_o, rsp_op_o, rsp_err_o, rsp_result_o, first.op, first.err, first.result);
      end
      n_checks++;
      if (start_o !== 1'b0) begin
        n_fail++;
        $display("FAIL stall_start[%0d]: start_o=%b, required 0", i, start_o);
      end
      @(posedge clk_i); #1;
    end
    rsp_ready_i = 1'b1;
    wait_rsps(2, "stall");
    while (obs_q.size() > 0) begin
      o = obs_q.pop_front();
      if (exp_q.size() == 0) e = '1; else e = exp_q.pop_front();
      n_checks++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL stall_rsp: got op=%0d err=%b res=%h, required op=%0d err=%b res=%h",
                 o.op, o.err, o.result, e.op, e.err, e.result);
      end
    end
  endtask

  task automatic test_reset_busy();
    int guard = 0;
    int starts0;
    done_delay = -1;
    push_cmd(3'd1, 8'h11, 8'h22);
    push_cmd(3'd3, 8'h33, 8'h44);
    push_cmd(3'd2, 8'h55, 8'h66);
    while (start_o !== 1'b1 && guard < 20) begin
      @(posedge clk_i); #1;
      guard++;
    end
    rst_i = 1'b1;
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    exp_q.delete();
    n_checks++;
    if ({start_o, rsp_valid_o, cmd_ready_o} !== 3'b001) begin
      n_fail++;
      $display("FAIL rst_busy_outputs: start=%b rsp_valid=%b ready=%b, required 0/0/1",
               start_o, rsp_valid_o, cmd_ready_o);
    end
    starts0 = n_starts;
    repeat (20) @(posedge clk_i);
    #1;
    n_checks++;
    if (n_starts != starts0 || obs_q.size() != 0) begin
      n_fail++;
      $display("FAIL rst_busy_drain: %0d starts and %0d responses after reset, required 0/0",
               n_starts - starts0, obs_q.size());
    end
    obs_q.delete();
    done_delay = 1;
  endtask

  task automatic test_random();
    rsp_t o, e;
    for (int i = 0; i < 24; i++) begin
      done_delay = int'($urandom_range(0, 4));
      push_cmd(3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom));
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk_i); #1;
      end
    end
    wait_rsps(24, "random");
    while (obs_q.size() > 0) begin
      o = obs_q.pop_front();
      if (exp_q.size() == 0) e = '1; else e = exp_q.pop_front();
      n_checks++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL random_rsp: got op=%0d err=%b res=%h, required op=%0d err=%b res=%h",
                 o.op, o.err, o.result, e.op, e.err, e.result);
      end
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_mul_backpressure();
    test_illegal_nop();
    test_timeout();
    test_rsp_stall();
    test_reset_busy();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/tiny_alu_issue_ctrl.md
TINY_ALU_ISSUE_CTRL -- requirements
Module: tiny_alu_issue_ctrl

Interface
REQ-001 Parameter INPUT_DATA_BITS, default 8, SHALL set the operand width; results SHALL be 2*INPUT_DATA_BITS wide.
REQ-002 Parameter OPCODE_BITS, default 3, SHALL set the opcode width.
REQ-003 Parameter FIFO_DEPTH, default 4, SHALL set the command buffer depth (power of two, >=2).
REQ-004 Parameter TIMEOUT_CYCLES, default 16, SHALL set the maximum number of cycles to wait for done_i.
REQ-005 Port clk_i, input, 1 bit, SHALL be the single clock; all logic is rising-edge.
REQ-006 Port rst_i, input, 1 bit, SHALL be the synchronous active-high reset.
REQ-007 Ports cmd_valid_i (in, 1), cmd_ready_o (out, 1), cmd_op_i (in, OPCODE_BITS), cmd_a_i and cmd_b_i (in, INPUT_DATA_BITS) SHALL form the upstream command channel.
REQ-008 Ports start_o (out, 1), op_o (out, OPCODE_BITS), a_o and b_o (out, INPUT_DATA_BITS) SHALL drive the tiny ALU.
REQ-009 Ports done_i (in, 1) and result_i (in, 2*INPUT_DATA_BITS) SHALL be the ALU outputs.
REQ-010 Ports rsp_valid_o (out, 1), rsp_ready_i (in, 1), rsp_result_o (out, 2*INPUT_DATA_BITS), rsp_op_o (out, OPCODE_BITS), rsp_err_o (out, 1) SHALL form the downstream response channel.

Function
REQ-011 A command SHALL be accepted on a rising edge where cmd_valid_i and cmd_ready_o are both 1.
REQ-012 cmd_ready_o SHALL equal NOT fifo_full; a push when full SHALL NOT occur, and a simultaneous push and pop SHALL both take effect.
REQ-013 Commands SHALL be issued strictly in acceptance order, one at a time.
REQ-014 FSM states SHALL be IDLE, BUSY and RESP.
REQ-015 IDLE: if the FIFO is non-empty, the head SHALL be popped into the op/a/b registers at that edge; legal ALU opcode (ADD=1, AND=2, XOR=3, MUL=4) -> BUSY; NOP=0 -> RESP with result 0, err 0; opcode 5..7 -> RESP with result 0, err 1.
REQ-016 BUSY: start_o SHALL be 1 and op_o/a_o/b_o SHALL be stable for the whole state.
REQ-017 A command pushed into an empty FIFO while in IDLE at edge N SHALL be popped at edge N+1, giving start_o=1 from edge N+2.
REQ-018 In BUSY, done_i=1 SHALL capture result_i into rsp_result_o, clear start_o at the same edge and move to RESP with err 0.
REQ-019 In BUSY, a cycle counter SHALL start at 0 on entry; if it reaches TIMEOUT_CYCLES-1 without done_i, the FSM SHALL move to RESP with result 0 and err 1, clearing start_o.
REQ-020 done_i outside BUSY SHALL be ignored.
REQ-021 RESP: rsp_valid_o SHALL be 1 with rsp_result_o/rsp_op_o/rsp_err_o stable until rsp_ready_i=1; on that edge the FSM SHALL go to IDLE.
REQ-022 NOP and illegal opcodes SHALL never assert start_o.
REQ-023 Back-to-back legal commands SHALL have start_o low for at least two cycles between operations (RESP plus IDLE).

Reset
REQ-024 While rst_i=1 at a rising edge: FSM -> IDLE, FIFO emptied, timeout counter 0.
REQ-025 Reset values: start_o 0, op_o/a_o/b_o 0, rsp_valid_o 0, rsp_result_o 0, rsp_op_o 0, rsp_err_o 0, cmd_ready_o 1 (from the cycle after reset).
REQ-026 Reset asserted in BUSY or RESP SHALL abandon the operation with no response emitted.

Structure
REQ-027 Shared package tiny_alu_pkg SHALL hold the opcode enum (NOP, ADD, AND, XOR, MUL), OPCODE_BITS, INPUT_DATA_BITS defaults and the FSM state typedef.
REQ-028 The command buffer SHALL be a separate sub-module, tiny_alu_issue_fifo (synchronous, registered, full/empty flags).

Verification
REQ-029 ADD a=8'h05, b=8'h07, ALU returns done after 1 cycle -> start_o pulses exactly 2 cycles, response 16'h000C, err 0, op 1.
REQ-030 MUL a=8'hFF, b=8'hFF, done after 3 cycles -> response 16'hFE01, err 0; four MULs pushed back-to-back: cmd_ready_o low after the fourth, responses returned in order.
REQ-031 Opcode 6 -> no start_o, response 0, err 1; NOP -> no start_o, response 0, err 0.
REQ-032 ADD with done_i held 0 -> start_o drops after 16 BUSY cycles, response 0, err 1.
REQ-033 rsp_ready_i held 0 for 5 cycles -> response fields stable, no new start_o; reset during BUSY -> start_o 0 next cycle, no response, FIFO empty.
